// File: rtl/pll_pkg.sv
// ---------------------------------------------------------------------------
// pll_pkg
// Definitions shared by the PLL datapath blocks (phase detector, loop filter).
//   ped_state_e : phase detector FSM states
//   err_max()   : largest signed error magnitude for a given error width. The
//                 negative full-scale code is never produced, so the range is
//                 symmetric.
// ---------------------------------------------------------------------------
package pll_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REF_LEAD = 2'd1,
        FB_LEAD  = 2'd2
    } ped_state_e;

    function automatic int err_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// ---------------------------------------------------------------------------
// edge_sync
// Brings an asynchronous clock-like input into the clk_i domain through a
// SYNC_STAGES-deep flop chain, then emits a one-cycle registered pulse on
// each rising edge. The pulse lags the input by SYNC_STAGES+1 cycles.
// Ports:
//   clk_i    : sampling clock
//   reset_i  : synchronous, active-high reset (clears every flop)
//   async_i  : asynchronous input, treated as data
//   rise_o   : one-cycle rising-edge pulse
// ---------------------------------------------------------------------------
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/phase_error_detector.sv
// ---------------------------------------------------------------------------
// phase_error_detector
// Counter-based phase/frequency detector feeding the loop filter. Reference
// and DCO feedback clocks are sampled as data; the gen_clk_i cycle distance
// between their rising edges is published as a signed, saturated error.
// Ports:
//   gen_clk_i     : sampling clock, the only clock
//   reset_i       : synchronous, active-high reset
//   ref_clk_i     : reference clock (asynchronous)
//   fb_clk_i      : DCO feedback clock (asynchronous)
//   error_o       : signed error, positive when ref leads (DCO too slow)
//   error_valid_o : one-cycle pulse marking a new result
//   lock_o        : high after LOCK_COUNT consecutive small results
// ---------------------------------------------------------------------------
module phase_error_detector
    import pll_pkg::*;
#(
    parameter int ERROR_WIDTH    = 8,
    parameter int SYNC_STAGES    = 2,
    parameter bit HOLD_ERROR     = 1'b0,
    parameter int LOCK_THRESH    = 2,
    parameter int LOCK_COUNT     = 16,
    parameter int LOCK_CNT_WIDTH = 5
) (
    input  logic                   gen_clk_i,
    input  logic                   reset_i,
    input  logic                   ref_clk_i,
    input  logic                   fb_clk_i,
    output logic [ERROR_WIDTH-1:0] error_o,
    output logic                   error_valid_o,
    output logic                   lock_o
);

    localparam int CNT_W = ERROR_WIDTH - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(err_max(ERROR_WIDTH));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic signed [ERROR_WIDTH-1:0] THR_POS = ERROR_WIDTH'(LOCK_THRESH);
    localparam logic signed [ERROR_WIDTH-1:0] THR_NEG = -THR_POS;
    localparam logic [LOCK_CNT_WIDTH-1:0] LOCK_MAX = LOCK_CNT_WIDTH'(LOCK_COUNT);

    logic ref_rise;
    logic fb_rise;

    ped_state_e                     state_q, state_d;
    logic [CNT_W-1:0]               count_q, count_d;
    logic signed [ERROR_WIDTH-1:0]  err_q, err_d;
    logic                           vld_q, vld_d;
    logic [LOCK_CNT_WIDTH-1:0]      lock_cnt_q, lock_cnt_d;
    logic                           lock_q, lock_d;

    logic                           pub_vld;
    logic                           pub_neg;
    logic [CNT_W-1:0]               pub_mag;
    logic signed [ERROR_WIDTH-1:0]  pub_val;
    logic [CNT_W-1:0]               count_inc;
    logic                           in_thresh;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
        .clk_i   (gen_clk_i),
        .reset_i (reset_i),
        .async_i (ref_clk_i),
        .rise_o  (ref_rise)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
        .clk_i   (gen_clk_i),
        .reset_i (reset_i),
        .async_i (fb_clk_i),
        .rise_o  (fb_rise)
    );

    // Saturating distance counter; it is loaded with 1 on the opening edge
    // so that it equals N in the cycle of a closing edge N cycles later.
    assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        count_d = count_inc;
        pub_vld = 1'b0;
        pub_neg = 1'b0;
        pub_mag = '0;
        unique case (state_q)
            IDLE: begin
                count_d = CNT_ONE;
                if (ref_rise && fb_rise) begin
                    pub_vld = 1'b1;
                end else if (ref_rise) begin
                    state_d = REF_LEAD;
                end else if (fb_rise) begin
                    state_d = FB_LEAD;
                end
            end
            REF_LEAD: begin
                if (fb_rise) begin
                    pub_vld = 1'b1;
                    pub_mag = count_q;
                    if (ref_rise) begin
                        count_d = CNT_ONE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (ref_rise) begin
                    // Feedback edge went missing: report full scale and
                    // start timing against the new reference edge.
                    pub_vld = 1'b1;
                    pub_mag = CNT_MAX;
                    count_d = CNT_ONE;
                end
            end
            FB_LEAD: begin
                pub_neg = 1'b1;
                if (ref_rise) begin
                    pub_vld = 1'b1;
                    pub_mag = count_q;
                    if (fb_rise) begin
                        count_d = CNT_ONE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (fb_rise) begin
                    pub_vld = 1'b1;
                    pub_mag = CNT_MAX;
                    count_d = CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Magnitude never exceeds ERR_MAX, so negation cannot overflow.
    always_comb begin
        pub_val = $signed({1'b0, pub_mag});
        if (pub_neg) begin
            pub_val = -$signed({1'b0, pub_mag});
        end
    end

    always_comb begin
        vld_d = pub_vld;
        if (pub_vld) begin
            err_d = pub_val;
        end else if (HOLD_ERROR) begin
            err_d = err_q;
        end else begin
            err_d = '0;
        end
    end

    // Lock tracking works on the published result; lock_q is loaded from the
    // next-state count so it moves in the cycle right after a valid pulse.
    assign in_thresh = (err_q >= THR_NEG) && (err_q <= THR_POS);

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (vld_q) begin
            if (!in_thresh) begin
                lock_cnt_d = '0;
            end else if (lock_cnt_q != LOCK_MAX) begin
                lock_cnt_d = lock_cnt_q + LOCK_CNT_WIDTH'(1);
            end
        end
        lock_d = (lock_cnt_d == LOCK_MAX);
    end

    always_ff @(posedge gen_clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            count_q    <= '0;
            err_q      <= '0;
            vld_q      <= 1'b0;
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            err_q      <= err_d;
            vld_q      <= vld_d;
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
        end
    end

    assign error_o       = err_q;
    assign error_valid_o = vld_q;
    assign lock_o        = lock_q;

endmodule

// File: tb/tb_phase_error_detector.sv
// ---------------------------------------------------------------------------
// tb_phase_error_detector
// Directed bench for phase_error_detector. Two instances share the stimulus:
// u_dut (impulse output) and u_dut_hold (output held between results).
// Inputs change and outputs are sampled on the falling edge of the clock.
// ---------------------------------------------------------------------------
module tb_phase_error_detector;

    logic clk = 1'b0;
    logic rst;
    logic ref_c;
    logic fb_c;
    logic signed [7:0] err0, err1;
    logic vld0, vld1, lock0, lock1;

    int n_chk  = 0;
    int n_pass = 0;

    phase_error_detector #(
        .ERROR_WIDTH(8), .SYNC_STAGES(2), .HOLD_ERROR(1'b0),
        .LOCK_THRESH(2), .LOCK_COUNT(16), .LOCK_CNT_WIDTH(5)
    ) u_dut (
        .gen_clk_i     (clk),
        .reset_i       (rst),
        .ref_clk_i     (ref_c),
        .fb_clk_i      (fb_c),
        .error_o       (err0),
        .error_valid_o (vld0),
        .lock_o        (lock0)
    );

    phase_error_detector #(
        .ERROR_WIDTH(8), .SYNC_STAGES(2), .HOLD_ERROR(1'b1),
        .LOCK_THRESH(2), .LOCK_COUNT(16), .LOCK_CNT_WIDTH(5)
    ) u_dut_hold (
        .gen_clk_i     (clk),
        .reset_i       (rst),
        .ref_clk_i     (ref_c),
        .fb_clk_i      (fb_c),
        .error_o       (err1),
        .error_valid_o (vld1),
        .lock_o        (lock1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Leader edge now, follower edge 'gap' cycles later (gap 0 = same cycle).
    // Returns latency from the follower drive to error_valid_o, the result,
    // lock_o in the valid cycle and one cycle later, and both error outputs
    // one cycle after the valid pulse.
    task automatic run_pair(input bit ref_first, input int gap,
                            output int lat, output int e,
                            output int lock_at, output int lock_after,
                            output int v_after, output int e_after,
                            output int e_hold_after);
        if (gap == 0) begin
            ref_c = 1'b1;
            fb_c  = 1'b1;
        end else begin
            if (ref_first) ref_c = 1'b1;
            else           fb_c  = 1'b1;
            for (int k = 1; k <= gap; k++) begin
                @(negedge clk);
                if (k == 2) begin
                    ref_c = 1'b0;
                    fb_c  = 1'b0;
                end
            end
            if (ref_first) fb_c  = 1'b1;
            else           ref_c = 1'b1;
        end
        lat = -1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (vld0) begin
                lat = c;
                break;
            end
        end
        e       = int'(err0);
        lock_at = int'(lock0);
        @(negedge clk);
        lock_after   = int'(lock0);
        v_after      = int'(vld0);
        e_after      = int'(err0);
        e_hold_after = int'(err1);
        ref_c = 1'b0;
        fb_c  = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int lat, e, la, lf, va, ea, eh;
        int seen;

        rst = 1'b1; ref_c = 1'b0; fb_c = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_err", int'(err0), 0);
        chk("reset_vld", int'(vld0), 0);
        chk("reset_lock", int'(lock0), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // ref leads fb by 5
        run_pair(1'b1, 5, lat, e, la, lf, va, ea, eh);
        chk("t1_latency", lat, 4);
        chk("t1_err", e, 5);
        chk("t1_vld_next", va, 0);
        chk("t1_err_next", ea, 0);

        // fb leads ref by 3, impulse vs hold instance
        run_pair(1'b0, 3, lat, e, la, lf, va, ea, eh);
        chk("t2_latency", lat, 4);
        chk("t2_err", e, -3);
        chk("t2_err_next", ea, 0);
        chk("t2_hold_next", eh, -3);
        chk("t2_hold_later", int'(err1), -3);

        // coincident edges, then saturated distance
        run_pair(1'b1, 0, lat, e, la, lf, va, ea, eh);
        chk("t3_same_latency", lat, 4);
        chk("t3_same_err", e, 0);
        chk("t3_hold_updated", eh, 0);
        run_pair(1'b1, 200, lat, e, la, lf, va, ea, eh);
        chk("t3_sat_latency", lat, 4);
        chk("t3_sat_err", e, 127);
        chk("t3_sat_err_next", ea, 0);

        // ref period 50 with fb missing
        for (int j = 0; j < 4; j++) begin
            ref_c = 1'b1;
            for (int c = 1; c <= 50; c++) begin
                @(negedge clk);
                if (c == 2) ref_c = 1'b0;
                if (c == 4) begin
                    chk($sformatf("t4_vld_%0d", j), int'(vld0), (j > 0) ? 1 : 0);
                    if (j > 0) chk($sformatf("t4_err_%0d", j), int'(err0), 127);
                    chk($sformatf("t4_lock_%0d", j), int'(lock0), 0);
                end
            end
        end
        fb_c = 1'b1;
        seen = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (vld0) begin
                seen = c;
                break;
            end
        end
        chk("t4_close_latency", seen, 4);
        chk("t4_close_err", int'(err0), 50);
        fb_c = 1'b0;
        repeat (6) @(negedge clk);

        // lock acquisition
        for (int i = 0; i < 16; i++) begin
            int g, ex;
            bit rf;
            g  = i % 3;
            rf = (i % 2) == 0;
            ex = (g == 0) ? 0 : (rf ? g : -g);
            run_pair(rf, g, lat, e, la, lf, va, ea, eh);
            chk($sformatf("t5_err_%0d", i), e, ex);
            if (i == 15) begin
                chk("t5_lock_at16", la, 0);
                chk("t5_lock_after16", lf, 1);
            end else if (i == 14) begin
                chk("t5_lock_after15", lf, 0);
            end
        end
        run_pair(1'b1, 4, lat, e, la, lf, va, ea, eh);
        chk("t5_out_err", e, 4);
        chk("t5_out_lock_at", la, 1);
        chk("t5_out_lock_after", lf, 0);
        for (int i = 0; i < 16; i++) begin
            run_pair(1'b0, 1, lat, e, la, lf, va, ea, eh);
            if (i == 14) chk("t5_relock_after15", lf, 0);
            if (i == 15) chk("t5_relock_after16", lf, 1);
        end

        // reset in REF_LEAD with count 7
        ref_c = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 2) ref_c = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_err", int'(err0), 0);
        chk("t6_rst_vld", int'(vld0), 0);
        chk("t6_rst_lock", int'(lock0), 0);
        chk("t6_rst_hold_err", int'(err1), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_post_err", int'(err0), 0);
        chk("t6_post_vld", int'(vld0), 0);
        chk("t6_post_lock", int'(lock0), 0);
        fb_c = 1'b1;
        seen = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 2) fb_c = 1'b0;
            if (vld0) seen++;
        end
        chk("t6_no_stale_result", seen, 0);
        ref_c = 1'b1;
        seen = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (vld0) begin
                seen = c;
                break;
            end
        end
        chk("t6_fb_lead_latency", seen, 4);
        chk("t6_fb_lead_err", int'(err0), -8);
        ref_c = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_lock_final", int'(lock0), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/phase_error_detector.md
Name: phase_error_detector

Overview:
- Counter-based digital phase/frequency detector that sits directly upstream of the loop filter.
- Samples the reference clock and the DCO feedback clock as data in the gen_clk_i domain.
- Measures the gen_clk_i cycle distance between their rising edges and publishes a signed, saturated phase error that the loop filter consumes on its error input.
- Also provides a lock indicator.

Parameters:
- ERROR_WIDTH, 8: width of the signed error output; must match the loop filter error width.
- SYNC_STAGES, 2: synchroniser flop stages per sampled clock input; minimum 2.
- HOLD_ERROR, 0: 1 = error_o holds its last result; 0 = error_o is nonzero only in the error_valid_o cycle (impulse mode, so the filter integrator does not over-integrate).
- LOCK_THRESH, 2: largest |error| counted as in-lock.
- LOCK_COUNT, 16: consecutive in-lock results required to assert lock_o.
- LOCK_CNT_WIDTH, 5: width of the lock counter; must hold LOCK_COUNT.

Ports:
- gen_clk_i  input  1  system sampling clock; the only clock.
- reset_i  input  1  synchronous, active-high reset.
- ref_clk_i  input  1  reference clock, asynchronous, treated as data.
- fb_clk_i  input  1  DCO feedback clock, asynchronous, treated as data.
- error_o  output  ERROR_WIDTH  signed phase error; positive means ref leads (DCO too slow).
- error_valid_o  output  1  one-cycle pulse when a new result is published.
- lock_o  output  1  lock indicator.

Behaviour:
- Clocking and reset: single clock, gen_clk_i, all logic on its rising edge. reset_i is synchronous and active-high.
- While reset_i is high, on each clock edge: synchronisers, edge registers, count, lock counter, error_o, error_valid_o and lock_o are all cleared to 0, and the FSM goes to IDLE.
- Reset mid-measurement aborts the measurement. No result is published for the aborted measurement.
- Front end: each input passes through SYNC_STAGES flops, then a rising-edge detector. The edge pulse lags the input by SYNC_STAGES+1 cycles. Both paths are identical, so relative timing is preserved.
- ERR_MAX = 2^(ERROR_WIDTH-1)-1. Magnitudes are symmetric; -2^(ERROR_WIDTH-1) is never output.
- Magnitude definition: opening edge pulse in cycle t, closing edge pulse in cycle t+N gives magnitude min(N, ERR_MAX). The count saturates and never wraps.
- FSM states: IDLE, REF_LEAD, FB_LEAD.
- IDLE transitions:
  - both edges in the same cycle: publish 0, stay in IDLE.
  - ref edge only: go to REF_LEAD, start count.
  - fb edge only: go to FB_LEAD, start count.
  - no edge: stay in IDLE.
- REF_LEAD transitions:
  - fb edge only: publish +count, go to IDLE.
  - ref edge only (fb edge missing): publish +ERR_MAX, restart count, stay in REF_LEAD.
  - both edges in the same cycle: publish +count, restart count, stay in REF_LEAD.
- FB_LEAD transitions: mirror of REF_LEAD with the sign negated.
- Publish timing: error_o and error_valid_o are registered. They update 1 cycle after the closing edge pulse, and error_valid_o is high for exactly that one cycle.
- Between results:
  - HOLD_ERROR=1: error_o holds its last value.
  - HOLD_ERROR=0: error_o is 0 in every cycle where error_valid_o is 0.
- Lock counter: counts only in error_valid_o cycles.
  - |e|<=LOCK_THRESH: increment, saturating at LOCK_COUNT.
  - otherwise, including saturated missing-edge results: clear to 0.
- lock_o: registered, equals (lock_cnt==LOCK_COUNT). It falls the cycle after an out-of-threshold result.
- Width rule: count is ERROR_WIDTH-1 bits, unsigned. The negative path is two's-complement negation of the saturated count.

Decomposition:
- Shared package (pll_pkg):
  - FSM state encoding constants (IDLE, REF_LEAD, FB_LEAD).
  - ERR_MAX as a constant function of ERROR_WIDTH, reused by the loop filter for saturation checks.
- One sub-module: edge_sync (SYNC_STAGES-deep synchroniser plus rising-edge pulse generator), instantiated once for ref_clk_i and once for fb_clk_i.

Test Plan:
All scenarios use ERROR_WIDTH=8 (ERR_MAX=127), SYNC_STAGES=2, HOLD_ERROR=0.
1. ref rising edge, then fb rising edge 5 gen_clk cycles later -> error_o=+5 with error_valid_o high for 1 cycle, 1 cycle after the fb edge pulse; error_o=0 on the next cycle.
2. fb edge leads ref edge by 3 cycles -> error_o=-3 (8'hFD). Same run with HOLD_ERROR=1 -> -3 held until the next result.
3. ref and fb edges in the same cycle -> error_o=0 with error_valid_o pulse, FSM stays in IDLE. fb edge 200 cycles after ref -> error_o=+127 (saturated, no wrap).
4. ref toggling with period 50, fb held low -> from the second ref edge onward, error_o=+127 every 50 cycles; lock_o stays 0.
5. 16 consecutive results in {-2..+2} -> lock_o rises 1 cycle after the 16th valid pulse. A following result of +4 -> lock_o falls 1 cycle later, and the count restarts from 0.
6. reset_i pulsed for 1 cycle while in REF_LEAD (count=7), then fb edge -> no +7 published; the fb edge opens FB_LEAD; all outputs read 0 during and right after reset.
